// File: rtl/ex_mem_stage_if.sv
// Data-memory bus between the EX/MEM stage (master) and a multi-cycle
// memory (slave). The request is level-held until a one-cycle done pulse.
interface ex_mem_stage_if;
    logic        memReq;
    logic        memWr;
    logic [15:0] memAddr;
    logic [15:0] memWData;
    logic [15:0] memRData;
    logic        memDone;

    modport master (
        output memReq, memWr, memAddr, memWData,
        input  memRData, memDone
    );

    modport slave (
        input  memReq, memWr, memAddr, memWData,
        output memRData, memDone
    );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: captures execute results into the M slot, runs a
// stall-based request/done handshake to a multi-cycle data memory, feeds the
// M-slot forwarding values back to execute and drives the MEM/WB register.
// Misaligned or timed-out accesses set a sticky error and complete as no-ops.
module ex_mem_stage #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        exValid_i,
    input  logic        exRegWrite_i,
    input  logic        exMemRead_i,
    input  logic        exMemWrite_i,
    input  logic        exHalt_i,
    input  logic [2:0]  exWriteReg_i,
    input  logic [1:0]  exWbSel_i,
    input  logic [15:0] aluFinal_i,
    input  logic [15:0] addPC_i,
    input  logic [15:0] imm8_i,
    input  logic [15:0] wrtDataXout_i,

    ex_mem_stage_if.master mem,

    output logic        stall_o,

    output logic [15:0] m2xALUData_o,
    output logic [15:0] m2xImm8Data_o,
    output logic [15:0] m2xAddPCData_o,
    output logic [15:0] m2xMemData_o,

    output logic        mValid_o,
    output logic        mRegWrite_o,
    output logic [2:0]  mWriteReg_o,
    output logic [1:0]  mWbSel_o,

    output logic        wbValid_o,
    output logic        wbRegWrite_o,
    output logic [2:0]  wbWriteReg_o,
    output logic [15:0] wbData_o,

    output logic        err_o,
    output logic        halted_o
);

    // Writeback source encoding, shared with the forwarding select.
    localparam logic [1:0] WB_ADDPC = 2'b00;
    localparam logic [1:0] WB_MEM   = 2'b01;
    localparam logic [1:0] WB_ALU   = 2'b10;
    localparam logic [1:0] WB_IMM8  = 2'b11;

    // Counter value seen during the last permitted request cycle.
    localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

    // M slot
    logic        mValid_q,    mValid_d;
    logic        mRegWrite_q, mRegWrite_d;
    logic        mMemRead_q,  mMemRead_d;
    logic        mMemWrite_q, mMemWrite_d;
    logic        mHalt_q,     mHalt_d;
    logic [2:0]  mWriteReg_q, mWriteReg_d;
    logic [1:0]  mWbSel_q,    mWbSel_d;
    logic [15:0] mAlu_q,      mAlu_d;
    logic [15:0] mAddPC_q,    mAddPC_d;
    logic [15:0] mImm8_q,     mImm8_d;
    logic [15:0] mWrtData_q,  mWrtData_d;
    logic [15:0] mMemData_q,  mMemData_d;
    logic        doneQ_q,     doneQ_d;
    logic [7:0]  cnt_q,       cnt_d;

    // WB slot and sticky status
    logic        wbValid_q,    wbValid_d;
    logic        wbRegWrite_q, wbRegWrite_d;
    logic        wbHalt_q,     wbHalt_d;
    logic [2:0]  wbWriteReg_q, wbWriteReg_d;
    logic [15:0] wbData_q,     wbData_d;
    logic        err_q,        err_d;
    logic        halted_q,     halted_d;

    logic        memOp;
    logic        misaligned;
    logic        memReq;
    logic        stall;
    logic        doneHit;
    logic        timeoutHit;
    logic        noopDone;
    logic [15:0] wbSelData;

    assign memOp      = mValid_q & (mMemRead_q | mMemWrite_q);
    assign misaligned = memOp & mAlu_q[0];
    assign memReq     = memOp & ~doneQ_q & ~misaligned & ~err_q;
    assign stall      = memOp & ~doneQ_q;

    // Completion events while the access is outstanding. A memory op that
    // cannot request (misaligned, or any op once err is set) finishes as a
    // no-op after one stall cycle so the pipe never locks up.
    assign doneHit    = memReq & mem.memDone;
    assign timeoutHit = memReq & ~mem.memDone & (cnt_q == TO_LAST);
    assign noopDone   = stall & ~memReq;

    assign mem.memReq   = memReq;
    assign mem.memWr    = mMemWrite_q;
    assign mem.memAddr  = mAlu_q;
    assign mem.memWData = mWrtData_q;

    assign stall_o        = stall;
    assign m2xALUData_o   = mAlu_q;
    assign m2xImm8Data_o  = mImm8_q;
    assign m2xAddPCData_o = mAddPC_q;
    assign m2xMemData_o   = mMemData_q;
    assign mValid_o       = mValid_q;
    assign mRegWrite_o    = mRegWrite_q;
    assign mWriteReg_o    = mWriteReg_q;
    assign mWbSel_o       = mWbSel_q;
    assign wbValid_o      = wbValid_q;
    assign wbRegWrite_o   = wbRegWrite_q;
    assign wbWriteReg_o   = wbWriteReg_q;
    assign wbData_o       = wbData_q;
    assign err_o          = err_q;
    assign halted_o       = halted_q;

    // Writeback data mux driven from the M slot.
    always_comb begin
        wbSelData = mAlu_q;
        case (mWbSel_q)
            WB_ADDPC: wbSelData = mAddPC_q;
            WB_MEM:   wbSelData = mMemData_q;
            WB_ALU:   wbSelData = mAlu_q;
            WB_IMM8:  wbSelData = mImm8_q;
            default:  wbSelData = mAlu_q;
        endcase
    end

    // Next-state: advance both slots when not stalled, otherwise hold M,
    // bubble WB and track the outstanding access.
    always_comb begin
        mValid_d     = mValid_q;
        mRegWrite_d  = mRegWrite_q;
        mMemRead_d   = mMemRead_q;
        mMemWrite_d  = mMemWrite_q;
        mHalt_d      = mHalt_q;
        mWriteReg_d  = mWriteReg_q;
        mWbSel_d     = mWbSel_q;
        mAlu_d       = mAlu_q;
        mAddPC_d     = mAddPC_q;
        mImm8_d      = mImm8_q;
        mWrtData_d   = mWrtData_q;
        mMemData_d   = mMemData_q;
        doneQ_d      = doneQ_q;
        cnt_d        = cnt_q;
        wbValid_d    = wbValid_q;
        wbRegWrite_d = wbRegWrite_q;
        wbHalt_d     = wbHalt_q;
        wbWriteReg_d = wbWriteReg_q;
        wbData_d     = wbData_q;
        err_d        = err_q;
        halted_d     = halted_q;

        if (stall) begin
            wbValid_d = 1'b0;
            if (memReq) begin
                cnt_d = cnt_q + 8'd1;
            end
            if (doneHit) begin
                doneQ_d = 1'b1;
                if (mMemRead_q) begin
                    mMemData_d = mem.memRData;
                end
            end else if (timeoutHit) begin
                doneQ_d    = 1'b1;
                err_d      = 1'b1;
                mMemData_d = 16'hFFFF;
            end else if (noopDone) begin
                doneQ_d    = 1'b1;
                mMemData_d = 16'h0000;
                if (misaligned) begin
                    err_d = 1'b1;
                end
            end
        end else begin
            mValid_d     = exValid_i;
            mRegWrite_d  = exRegWrite_i;
            mMemRead_d   = exMemRead_i;
            mMemWrite_d  = exMemWrite_i;
            mHalt_d      = exHalt_i;
            mWriteReg_d  = exWriteReg_i;
            mWbSel_d     = exWbSel_i;
            mAlu_d       = aluFinal_i;
            mAddPC_d     = addPC_i;
            mImm8_d      = imm8_i;
            mWrtData_d   = wrtDataXout_i;
            doneQ_d      = 1'b0;
            cnt_d        = 8'd0;

            wbValid_d    = mValid_q;
            // Stores never write the register file.
            wbRegWrite_d = mRegWrite_q & ~mMemWrite_q;
            wbHalt_d     = mHalt_q;
            wbWriteReg_d = mWriteReg_q;
            wbData_d     = wbSelData;
        end

        if (wbValid_q & wbHalt_q) begin
            halted_d = 1'b1;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mValid_q     <= 1'b0;
            mRegWrite_q  <= 1'b0;
            mMemRead_q   <= 1'b0;
            mMemWrite_q  <= 1'b0;
            mHalt_q      <= 1'b0;
            mWriteReg_q  <= 3'd0;
            mWbSel_q     <= 2'd0;
            mAlu_q       <= 16'h0000;
            mAddPC_q     <= 16'h0000;
            mImm8_q      <= 16'h0000;
            mWrtData_q   <= 16'h0000;
            mMemData_q   <= 16'h0000;
            doneQ_q      <= 1'b0;
            cnt_q        <= 8'd0;
            wbValid_q    <= 1'b0;
            wbRegWrite_q <= 1'b0;
            wbHalt_q     <= 1'b0;
            wbWriteReg_q <= 3'd0;
            wbData_q     <= 16'h0000;
            err_q        <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            mValid_q     <= mValid_d;
            mRegWrite_q  <= mRegWrite_d;
            mMemRead_q   <= mMemRead_d;
            mMemWrite_q  <= mMemWrite_d;
            mHalt_q      <= mHalt_d;
            mWriteReg_q  <= mWriteReg_d;
            mWbSel_q     <= mWbSel_d;
            mAlu_q       <= mAlu_d;
            mAddPC_q     <= mAddPC_d;
            mImm8_q      <= mImm8_d;
            mWrtData_q   <= mWrtData_d;
            mMemData_q   <= mMemData_d;
            doneQ_q      <= doneQ_d;
            cnt_q        <= cnt_d;
            wbValid_q    <= wbValid_d;
            wbRegWrite_q <= wbRegWrite_d;
            wbHalt_q     <= wbHalt_d;
            wbWriteReg_q <= wbWriteReg_d;
            wbData_q     <= wbData_d;
            err_q        <= err_d;
            halted_q     <= halted_d;
        end
    end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed testbench for ex_mem_stage with hand-computed expectations.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        exValid, exRegWrite, exMemRead, exMemWrite, exHalt;
    logic [2:0]  exWriteReg;
    logic [1:0]  exWbSel;
    logic [15:0] aluFinal, addPC, imm8, wrtDataXout;
    logic        stall;
    logic [15:0] m2xALUData, m2xImm8Data, m2xAddPCData, m2xMemData;
    logic        mValid, mRegWrite;
    logic [2:0]  mWriteReg;
    logic [1:0]  mWbSel;
    logic        wbValid, wbRegWrite;
    logic [2:0]  wbWriteReg;
    logic [15:0] wbData;
    logic        err, halted;

    int n_pass  = 0;
    int n_total = 0;

    ex_mem_stage_if mem_if ();

    ex_mem_stage #(.MEM_TIMEOUT(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .exValid_i     (exValid),
        .exRegWrite_i  (exRegWrite),
        .exMemRead_i   (exMemRead),
        .exMemWrite_i  (exMemWrite),
        .exHalt_i      (exHalt),
        .exWriteReg_i  (exWriteReg),
        .exWbSel_i     (exWbSel),
        .aluFinal_i    (aluFinal),
        .addPC_i       (addPC),
        .imm8_i        (imm8),
        .wrtDataXout_i (wrtDataXout),
        .mem           (mem_if.master),
        .stall_o       (stall),
        .m2xALUData_o  (m2xALUData),
        .m2xImm8Data_o (m2xImm8Data),
        .m2xAddPCData_o(m2xAddPCData),
        .m2xMemData_o  (m2xMemData),
        .mValid_o      (mValid),
        .mRegWrite_o   (mRegWrite),
        .mWriteReg_o   (mWriteReg),
        .mWbSel_o      (mWbSel),
        .wbValid_o     (wbValid),
        .wbRegWrite_o  (wbRegWrite),
        .wbWriteReg_o  (wbWriteReg),
        .wbData_o      (wbData),
        .err_o         (err),
        .halted_o      (halted)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic v, input logic rw, input logic mr, input logic mw,
                          input logic h, input logic [2:0] wr, input logic [1:0] sel,
                          input logic [15:0] alu, input logic [15:0] wdat);
        exValid = v; exRegWrite = rw; exMemRead = mr; exMemWrite = mw; exHalt = h;
        exWriteReg = wr; exWbSel = sel; aluFinal = alu; wrtDataXout = wdat;
        addPC = 16'h0102; imm8 = 16'h0033;
    endtask

    task automatic bubble();
        set_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 16'h0000, 16'h0000);
    endtask

    task automatic test_reset();
        bubble();
        mem_if.memDone = 1'b0; mem_if.memRData = 16'h0000;
        rst_n = 1'b0;
        step(); step();
        n_total++; if (mValid !== 1'b0) $display("FAIL rst_mValid got=%0h want=0", mValid); else n_pass++;
        n_total++; if (wbData !== 16'h0000) $display("FAIL rst_wbData got=%h want=0000", wbData); else n_pass++;
        rst_n = 1'b1;
        // load issued, then reset asserted during request cycle 2
        set_ex(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 2'b01, 16'h0080, 16'h0000);
        step();
        n_total++; if (mem_if.memReq !== 1'b1) $display("FAIL rstacc_req_c1 got=%0h want=1", mem_if.memReq); else n_pass++;
        step();
        rst_n = 1'b0;
        #1;
        n_total++; if (mem_if.memReq !== 1'b0) $display("FAIL rstacc_memReq got=%0h want=0", mem_if.memReq); else n_pass++;
        n_total++; if (stall !== 1'b0) $display("FAIL rstacc_stall got=%0h want=0", stall); else n_pass++;
        n_total++; if (mValid !== 1'b0) $display("FAIL rstacc_mValid got=%0h want=0", mValid); else n_pass++;
        n_total++; if (wbValid !== 1'b0) $display("FAIL rstacc_wbValid got=%0h want=0", wbValid); else n_pass++;
        n_total++; if (m2xALUData !== 16'h0000) $display("FAIL rstacc_m2xALU got=%h want=0000", m2xALUData); else n_pass++;
        n_total++; if (err !== 1'b0 || halted !== 1'b0) $display("FAIL rstacc_err_halt got=%0h%0h want=00", err, halted); else n_pass++;
        bubble();
        #1 rst_n = 1'b1;
        step();
    endtask

    task automatic test_alu_pass();
        set_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 2'b10, 16'h1234, 16'h0000);
        step();
        n_total++; if (m2xALUData !== 16'h1234) $display("FAIL alu_m2x got=%h want=1234", m2xALUData); else n_pass++;
        n_total++; if (stall !== 1'b0) $display("FAIL alu_stall1 got=%0h want=0", stall); else n_pass++;
        bubble();
        step();
        n_total++; if (wbData !== 16'h1234) $display("FAIL alu_wbData got=%h want=1234", wbData); else n_pass++;
        n_total++; if (wbWriteReg !== 3'd3) $display("FAIL alu_wbWriteReg got=%0d want=3", wbWriteReg); else n_pass++;
        n_total++; if (wbValid !== 1'b1 || wbRegWrite !== 1'b1) $display("FAIL alu_wbValid_rw got=%0h%0h want=11", wbValid, wbRegWrite); else n_pass++;
        n_total++; if (stall !== 1'b0) $display("FAIL alu_stall2 got=%0h want=0", stall); else n_pass++;
        step();
    endtask

    task automatic test_load_latency();
        set_ex(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd5, 2'b01, 16'h0040, 16'h0000);
        step();
        // cycle 1
        n_total++; if (stall !== 1'b1 || mem_if.memReq !== 1'b1 || mem_if.memWr !== 1'b0) $display("FAIL ld_c1 stall/req/wr got=%0h%0h%0h want=110", stall, mem_if.memReq, mem_if.memWr); else n_pass++;
        n_total++; if (mem_if.memAddr !== 16'h0040) $display("FAIL ld_addr_c1 got=%h want=0040", mem_if.memAddr); else n_pass++;
        step();
        // cycle 2
        n_total++; if (stall !== 1'b1 || wbValid !== 1'b0) $display("FAIL ld_c2 stall/wbValid got=%0h%0h want=10", stall, wbValid); else n_pass++;
        n_total++; if (mem_if.memAddr !== 16'h0040) $display("FAIL ld_addr_c2 got=%h want=0040", mem_if.memAddr); else n_pass++;
        step();
        // cycle 3: memory completes
        n_total++; if (stall !== 1'b1 || mem_if.memReq !== 1'b1 || wbValid !== 1'b0) $display("FAIL ld_c3 stall/req/wbValid got=%0h%0h%0h want=110", stall, mem_if.memReq, wbValid); else n_pass++;
        mem_if.memDone = 1'b1; mem_if.memRData = 16'hBEEF;
        step();
        mem_if.memDone = 1'b0; mem_if.memRData = 16'h0000;
        // cycle 4: done, ready to advance
        n_total++; if (stall !== 1'b0 || mem_if.memReq !== 1'b0) $display("FAIL ld_c4 stall/req got=%0h%0h want=00", stall, mem_if.memReq); else n_pass++;
        n_total++; if (m2xMemData !== 16'hBEEF) $display("FAIL ld_m2xMem got=%h want=BEEF", m2xMemData); else n_pass++;
        n_total++; if (wbValid !== 1'b0) $display("FAIL ld_bubble3 got=%0h want=0", wbValid); else n_pass++;
        bubble();
        step();
        n_total++; if (wbValid !== 1'b1 || wbData !== 16'hBEEF) $display("FAIL ld_wb got=%0h/%h want=1/BEEF", wbValid, wbData); else n_pass++;
        n_total++; if (wbWriteReg !== 3'd5) $display("FAIL ld_wbWriteReg got=%0d want=5", wbWriteReg); else n_pass++;
    endtask

    task automatic test_store();
        set_ex(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd2, 2'b10, 16'h0010, 16'hA5A5);
        step();
        n_total++; if (mem_if.memReq !== 1'b1 || mem_if.memWr !== 1'b1 || stall !== 1'b1) $display("FAIL st_c1 req/wr/stall got=%0h%0h%0h want=111", mem_if.memReq, mem_if.memWr, stall); else n_pass++;
        n_total++; if (mem_if.memWData !== 16'hA5A5 || mem_if.memAddr !== 16'h0010) $display("FAIL st_bus got=%h/%h want=A5A5/0010", mem_if.memWData, mem_if.memAddr); else n_pass++;
        mem_if.memDone = 1'b1;
        step();
        mem_if.memDone = 1'b0;
        n_total++; if (stall !== 1'b0) $display("FAIL st_c2_stall got=%0h want=0", stall); else n_pass++;
        n_total++; if (m2xMemData !== 16'hBEEF) $display("FAIL st_memdata_kept got=%h want=BEEF", m2xMemData); else n_pass++;
        bubble();
        step();
        n_total++; if (wbValid !== 1'b1 || wbRegWrite !== 1'b0) $display("FAIL st_wb valid/rw got=%0h%0h want=10", wbValid, wbRegWrite); else n_pass++;
    endtask

    task automatic test_misaligned();
        set_ex(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd4, 2'b01, 16'h0011, 16'h0000);
        step();
        n_total++; if (mem_if.memReq !== 1'b0 || stall !== 1'b1 || err !== 1'b0) $display("FAIL mis_c1 req/stall/err got=%0h%0h%0h want=010", mem_if.memReq, stall, err); else n_pass++;
        step();
        n_total++; if (err !== 1'b1 || stall !== 1'b0 || mem_if.memReq !== 1'b0) $display("FAIL mis_c2 err/stall/req got=%0h%0h%0h want=100", err, stall, mem_if.memReq); else n_pass++;
        n_total++; if (m2xMemData !== 16'h0000) $display("FAIL mis_m2xMem got=%h want=0000", m2xMemData); else n_pass++;
        set_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd6, 2'b10, 16'h0777, 16'h0000);
        step();
        n_total++; if (wbValid !== 1'b1 || wbData !== 16'h0000) $display("FAIL mis_wb got=%0h/%h want=1/0000", wbValid, wbData); else n_pass++;
        bubble();
        step();
        n_total++; if (wbData !== 16'h0777 || wbWriteReg !== 3'd6 || wbRegWrite !== 1'b1) $display("FAIL mis_next_alu got=%h/%0d/%0h want=0777/6/1", wbData, wbWriteReg, wbRegWrite); else n_pass++;
        n_total++; if (err !== 1'b1) $display("FAIL mis_err_sticky got=%0h want=1", err); else n_pass++;
    endtask

    task automatic test_timeout_halt();
        int req_cycles = 0;
        bool_done: begin end
        bubble();
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        step();
        n_total++; if (err !== 1'b0) $display("FAIL to_err_cleared got=%0h want=0", err); else n_pass++;
        set_ex(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 2'b01, 16'h0020, 16'h0000);
        step();
        for (int i = 0; i < 20; i++) begin
            if (mem_if.memReq === 1'b1) req_cycles++;
            if (stall !== 1'b1) break;
            step();
        end
        n_total++; if (stall !== 1'b0) $display("FAIL to_stall_bound got=%0h want=0", stall); else n_pass++;
        n_total++; if (req_cycles != 4) $display("FAIL to_req_cycles got=%0d want=4", req_cycles); else n_pass++;
        n_total++; if (err !== 1'b1 || m2xMemData !== 16'hFFFF) $display("FAIL to_err_data got=%0h/%h want=1/FFFF", err, m2xMemData); else n_pass++;
        set_ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 2'b10, 16'h0000, 16'h0000);
        step();
        n_total++; if (wbValid !== 1'b1 || wbData !== 16'hFFFF) $display("FAIL to_wb got=%0h/%h want=1/FFFF", wbValid, wbData); else n_pass++;
        set_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd7, 2'b11, 16'h0000, 16'h0000);
        step();
        n_total++; if (halted !== 1'b0) $display("FAIL halt_early got=%0h want=0", halted); else n_pass++;
        bubble();
        step();
        n_total++; if (halted !== 1'b1) $display("FAIL halt_set got=%0h want=1", halted); else n_pass++;
        n_total++; if (wbData !== 16'h0033 || wbWriteReg !== 3'd7) $display("FAIL halt_flow got=%h/%0d want=0033/7", wbData, wbWriteReg); else n_pass++;
        step();
        n_total++; if (halted !== 1'b1) $display("FAIL halt_sticky got=%0h want=1", halted); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_alu_pass();
        test_load_latency();
        test_store();
        test_misaligned();
        test_timeout_halt();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
